// File: rtl/spi_resp_pkg.sv
// Shared definitions for the SPI RAM responder: FSM encoding, opcodes and
// the number of address bytes in a 23LC-style command.
package spi_resp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_READ   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_IGNORE = 3'd5
    } state_t;

    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam int         ADDR_BYTES = 3;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous input, with a
// selectable value loaded while reset is asserted.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/spi_ram_responder.sv
// SPI mode-0 target fronting a small byte RAM; answers READ/WRITE commands
// with a 24-bit address. All SPI pins are oversampled in the clk domain.
module spi_ram_responder
    import spi_resp_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic miso,
    output logic miso_oe,
    output logic busy,
    output logic cmd_err
);

    logic w_sclk_s, w_cs_n_s, w_mosi_s;

    sync2 #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .i_d(sclk), .o_q(w_sclk_s));
    sync2 #(.RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst_n(rst_n), .i_d(cs_n), .o_q(w_cs_n_s));
    sync2 #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .i_d(mosi), .o_q(w_mosi_s));

    state_t        r_state;
    logic          r_sclk_d;
    logic          r_cs_n_d;
    logic [2:0]    r_bit_cnt;
    logic [1:0]    r_addr_byte;
    logic [6:0]    r_rx_sr;
    logic [7:0]    r_tx_sr;
    logic [AW-1:0] r_addr;
    logic          r_is_read;
    logic          r_load_tx;
    logic [7:0]    r_rd_data;
    logic [7:0]    mem [0:(1<<AW)-1];

    logic          w_rise, w_fall, w_cs_fall, w_last_bit, w_addr_done, w_mem_we;
    logic [7:0]    w_rx_byte;
    logic [AW-1:0] w_addr_shift, w_mem_addr;

    // Edges are gated by cs so a same-cycle deassert drops the bit.
    assign w_rise       = w_sclk_s & ~r_sclk_d & ~w_cs_n_s;
    assign w_fall       = ~w_sclk_s & r_sclk_d & ~w_cs_n_s;
    assign w_cs_fall    = r_cs_n_d & ~w_cs_n_s;
    assign w_rx_byte    = {r_rx_sr, w_mosi_s};
    assign w_last_bit   = w_rise & (r_bit_cnt == 3'd7);
    assign w_addr_shift = {r_addr[AW-2:0], w_mosi_s};
    assign w_addr_done  = (r_state == ST_ADDR) & w_last_bit &
                          (r_addr_byte == 2'(ADDR_BYTES - 1));
    assign w_mem_addr   = (r_state == ST_ADDR) ? w_addr_shift : r_addr;
    assign w_mem_we     = rst_n & (r_state == ST_WRITE) & w_last_bit;
    assign busy         = (r_state != ST_IDLE);

    // Single port, read-first; the read register feeds tx_sr one clk later.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem[w_mem_addr] <= w_rx_byte;
        end
        r_rd_data <= mem[w_mem_addr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_sclk_d    <= 1'b0;
            r_cs_n_d    <= 1'b1;
            r_bit_cnt   <= 3'd0;
            r_addr_byte <= 2'd0;
            r_rx_sr     <= 7'd0;
            r_tx_sr     <= 8'd0;
            r_addr      <= '0;
            r_is_read   <= 1'b0;
            r_load_tx   <= 1'b0;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            r_sclk_d  <= w_sclk_s;
            r_cs_n_d  <= w_cs_n_s;
            r_load_tx <= 1'b0;
            if (w_cs_n_s) begin
                r_state <= ST_IDLE;
                miso_oe <= 1'b0;
                miso    <= 1'b0;
            end else begin
                if (w_rise) begin
                    r_rx_sr   <= w_rx_byte[6:0];
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                case (r_state)
                    ST_IDLE: begin
                        if (w_cs_fall) begin
                            r_state     <= ST_CMD;
                            r_bit_cnt   <= 3'd0;
                            r_addr_byte <= 2'd0;
                            miso_oe     <= 1'b1;
                        end
                    end
                    ST_CMD: begin
                        if (w_last_bit) begin
                            if (w_rx_byte == CMD_READ || w_rx_byte == CMD_WRITE) begin
                                r_state   <= ST_ADDR;
                                r_is_read <= (w_rx_byte == CMD_READ);
                                cmd_err   <= 1'b0;
                            end else begin
                                r_state <= ST_IGNORE;
                                cmd_err <= 1'b1;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (w_rise) begin
                            r_addr <= w_addr_shift;
                        end
                        if (w_last_bit) begin
                            r_addr_byte <= r_addr_byte + 2'd1;
                        end
                        if (w_addr_done) begin
                            if (r_is_read) begin
                                r_state   <= ST_READ;
                                r_load_tx <= 1'b1;
                                r_addr    <= w_addr_shift + AW'(1);
                            end else begin
                                r_state <= ST_WRITE;
                            end
                        end
                    end
                    ST_READ: begin
                        if (w_fall) begin
                            miso    <= r_tx_sr[7];
                            r_tx_sr <= {r_tx_sr[6:0], 1'b0};
                        end
                        if (w_last_bit) begin
                            r_load_tx <= 1'b1;
                            r_addr    <= r_addr + AW'(1);
                        end
                    end
                    ST_WRITE: begin
                        if (w_last_bit) begin
                            r_addr <= r_addr + AW'(1);
                        end
                    end
                    ST_IGNORE: begin
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
            if (r_load_tx) begin
                r_tx_sr <= r_rd_data;
            end
        end
    end

endmodule
